// File: rtl/sdram_frame_writer.sv
// Write-side address generator for the ping-pong SDRAM frame buffer.
// Moves one frame from the write FIFO into SDRAM as burst requests.
module sdram_frame_writer #(
  parameter int FRAME_WORDS = 307200,
  parameter int BURST_LEN   = 256,
  parameter int BANK_W      = 2,
  parameter int WADDR_W     = 20,
  parameter int USEDW_W     = 10
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_wr_load,
  input  logic [BANK_W-1:0]         i_wr_bank,
  input  logic [USEDW_W-1:0]        i_fifo_usedw,
  output logic                      o_wr_req,
  input  logic                      i_wr_ack,
  input  logic                      i_wr_burst_done,
  output logic [BANK_W+WADDR_W-1:0] o_wr_addr,
  output logic [8:0]                o_wr_burst_len,
  output logic                      o_frame_write_done
);

  // One extra bit so the offset can hold FRAME_WORDS exactly at frame end.
  localparam int OFF_W = WADDR_W + 1;
  localparam logic [OFF_W-1:0] FRAME_L = OFF_W'(FRAME_WORDS);
  localparam logic [OFF_W-1:0] BURST_L = OFF_W'(BURST_LEN);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_REQ   = 2'd2,
    S_BURST = 2'd3
  } state_t;

  state_t             r_state;
  logic [OFF_W-1:0]   r_offset;
  logic [BANK_W-1:0]  r_bank;
  logic [BANK_W-1:0]  r_bank_pend;
  logic               r_load_pend;

  logic [OFF_W-1:0]   w_remain;
  logic [8:0]         w_blen;
  logic               w_fifo_ok;
  logic [OFF_W-1:0]   w_next_off;

  assign w_remain   = FRAME_L - r_offset;
  assign w_blen     = (w_remain < BURST_L) ? 9'(w_remain) : 9'(BURST_LEN);
  assign w_fifo_ok  = (32'(i_fifo_usedw) >= 32'(w_blen));
  // The latched burst length is the blen of the burst in flight.
  assign w_next_off = r_offset + OFF_W'(o_wr_burst_len);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state            <= S_IDLE;
      r_offset           <= '0;
      r_bank             <= '0;
      r_bank_pend        <= '0;
      r_load_pend        <= 1'b0;
      o_wr_req           <= 1'b0;
      o_wr_addr          <= '0;
      o_wr_burst_len     <= '0;
      o_frame_write_done <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_wr_load) begin
            r_bank             <= i_wr_bank;
            r_offset           <= '0;
            r_load_pend        <= 1'b0;
            o_frame_write_done <= 1'b0;
            r_state            <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (i_wr_load) begin
            r_bank   <= i_wr_bank;
            r_offset <= '0;
          end else if (w_fifo_ok) begin
            o_wr_req       <= 1'b1;
            o_wr_addr      <= {r_bank, r_offset[WADDR_W-1:0]};
            o_wr_burst_len <= w_blen;
            r_state        <= S_REQ;
          end
        end

        S_REQ: begin
          if (i_wr_load) begin
            r_load_pend <= 1'b1;
            r_bank_pend <= i_wr_bank;
          end
          if (i_wr_ack) begin
            o_wr_req <= 1'b0;
            r_state  <= S_BURST;
          end
        end

        S_BURST: begin
          if (i_wr_burst_done) begin
            // A restart (fresh or deferred) takes priority over advancing.
            if (i_wr_load) begin
              r_bank      <= i_wr_bank;
              r_offset    <= '0;
              r_load_pend <= 1'b0;
              r_state     <= S_WAIT;
            end else if (r_load_pend) begin
              r_bank      <= r_bank_pend;
              r_offset    <= '0;
              r_load_pend <= 1'b0;
              r_state     <= S_WAIT;
            end else begin
              r_offset <= w_next_off;
              if (w_next_off == FRAME_L) begin
                o_frame_write_done <= 1'b1;
                r_state            <= S_IDLE;
              end else begin
                r_state <= S_WAIT;
              end
            end
          end else if (i_wr_load) begin
            r_load_pend <= 1'b1;
            r_bank_pend <= i_wr_bank;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_frame_writer.sv
// Randomized bench for sdram_frame_writer: a small SDRAM-controller responder
// driven from tasks, checked against a burst list computed from frame arithmetic.
module tb_sdram_frame_writer;

  localparam int FW      = 600;
  localparam int BL      = 256;
  localparam int BANK_W  = 2;
  localparam int WADDR_W = 10;
  localparam int USEDW_W = 10;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic                      load;
  logic [BANK_W-1:0]         bank;
  logic [USEDW_W-1:0]        usedw;
  logic                      ack;
  logic                      bdone;
  logic                      o_req;
  logic [BANK_W+WADDR_W-1:0] o_addr;
  logic [8:0]                o_len;
  logic                      o_done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sdram_frame_writer #(
    .FRAME_WORDS(FW), .BURST_LEN(BL), .BANK_W(BANK_W),
    .WADDR_W(WADDR_W), .USEDW_W(USEDW_W)
  ) dut (
    .i_clk             (clk),
    .i_rst_n           (rst_n),
    .i_wr_load         (load),
    .i_wr_bank         (bank),
    .i_fifo_usedw      (usedw),
    .o_wr_req          (o_req),
    .i_wr_ack          (ack),
    .i_wr_burst_done   (bdone),
    .o_wr_addr         (o_addr),
    .o_wr_burst_len    (o_len),
    .o_frame_write_done(o_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_addr(input logic [1:0] b, input int off);
    return 32'({b, 10'(off)});
  endfunction

  task automatic start_frame(input logic [1:0] b);
    @(negedge clk);
    load = 1'b1; bank = b; usedw = '0;
    @(negedge clk);
    load = 1'b0; bank = 2'($urandom);
    check("done_low_after_load", 32'(o_done), 32'd0);
  endtask

  // Holds the FIFO below blen (with stray ack/done pulses), then releases it
  // and plays a controller that acknowledges after ack_dly cycles.
  task automatic issue(input logic [1:0] b, input int off, input int len, input int ack_dly);
    int n;
    n = $urandom_range(0, 4);
    usedw = 10'($urandom_range(0, len - 1));
    repeat (n) begin
      ack   = 1'($urandom_range(0, 1));
      bdone = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("no_req_below_blen", 32'(o_req), 32'd0);
    end
    ack = 1'b0; bdone = 1'b0;
    usedw = 10'($urandom_range(len, 1023));
    @(negedge clk);
    check("req_raised", 32'(o_req), 32'd1);
    check("req_addr", 32'(o_addr), exp_addr(b, off));
    check("req_len", 32'(o_len), 32'(len));
    check("done_low_in_frame", 32'(o_done), 32'd0);
    repeat (ack_dly) begin
      usedw = 10'($urandom);
      @(negedge clk);
      check("req_held", 32'(o_req), 32'd1);
      check("addr_held", 32'(o_addr), exp_addr(b, off));
      check("len_held", 32'(o_len), 32'(len));
    end
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    check("req_drop_on_ack", 32'(o_req), 32'd0);
  endtask

  task automatic complete(input logic ld, input logic [1:0] b, input logic exp_done);
    int d;
    d = $urandom_range(0, 5);
    repeat (d) begin
      ack = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    ack = 1'b0; bdone = 1'b1; usedw = '0;
    if (ld) begin
      load = 1'b1; bank = b;
    end
    check("done_low_in_burst", 32'(o_done), 32'd0);
    @(negedge clk);
    bdone = 1'b0; load = 1'b0; bank = 2'($urandom);
    check("done_after_burst", 32'(o_done), 32'(exp_done));
    check("req_low_after_burst", 32'(o_req), 32'd0);
  endtask

  task automatic frame_from(input logic [1:0] b, input int off0);
    int off;
    int len;
    off = off0;
    while (off < FW) begin
      len = (FW - off < BL) ? FW - off : BL;
      issue(b, off, len, $urandom_range(0, 5));
      off += len;
      complete(1'b0, 2'b00, off == FW);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0] rb;
    rst_n = 1'b0; load = 1'b0; bank = '0; usedw = '0; ack = 1'b0; bdone = 1'b0;
    #12;
    check("rst_req", 32'(o_req), 32'd0);
    check("rst_addr", 32'(o_addr), 32'd0);
    check("rst_len", 32'(o_len), 32'd0);
    check("rst_done", 32'(o_done), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    usedw = 10'd1023;
    repeat (20) begin
      @(negedge clk);
      check("idle_no_req", 32'(o_req), 32'd0);
      check("idle_done", 32'(o_done), 32'd1);
    end

    // Full frame on bank 01: 256, 256, 88.
    start_frame(2'b01);
    frame_from(2'b01, 0);

    // FIFO threshold and a 5-cycle ack delay.
    start_frame(2'b00);
    usedw = 10'd100;
    repeat (10) begin
      @(negedge clk);
      check("no_req_usedw100", 32'(o_req), 32'd0);
    end
    usedw = 10'd255;
    @(negedge clk);
    check("no_req_usedw255", 32'(o_req), 32'd0);
    usedw = 10'd256;
    @(negedge clk);
    check("req_usedw256", 32'(o_req), 32'd1);
    check("req_usedw256_addr", 32'(o_addr), exp_addr(2'b00, 0));
    check("req_usedw256_len", 32'(o_len), 32'd256);
    repeat (5) begin
      @(negedge clk);
      check("ack5_req", 32'(o_req), 32'd1);
      check("ack5_addr", 32'(o_addr), exp_addr(2'b00, 0));
      check("ack5_len", 32'(o_len), 32'd256);
    end
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    check("ack5_drop", 32'(o_req), 32'd0);
    complete(1'b0, 2'b00, 1'b0);
    frame_from(2'b00, 256);

    // Restart requested mid-BURST.
    start_frame(2'b00);
    issue(2'b00, 0, 256, 2);
    @(negedge clk);
    load = 1'b1; bank = 2'b11;
    @(negedge clk);
    load = 1'b0; bank = 2'($urandom);
    complete(1'b0, 2'b00, 1'b0);
    frame_from(2'b11, 0);

    // Restart requested during REQ: request held, then restart after burst.
    start_frame(2'b10);
    usedw = 10'd1023;
    @(negedge clk);
    check("reqload_req", 32'(o_req), 32'd1);
    load = 1'b1; bank = 2'b01;
    @(negedge clk);
    load = 1'b0; bank = 2'($urandom);
    check("reqload_req_held", 32'(o_req), 32'd1);
    check("reqload_addr_held", 32'(o_addr), exp_addr(2'b10, 0));
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    complete(1'b0, 2'b00, 1'b0);
    frame_from(2'b01, 0);

    // Restart while waiting for FIFO data.
    start_frame(2'b01);
    @(negedge clk);
    load = 1'b1; bank = 2'b10;
    @(negedge clk);
    load = 1'b0; bank = 2'($urandom);
    frame_from(2'b10, 0);

    // wr_load coincident with the final wr_burst_done.
    start_frame(2'b11);
    issue(2'b11, 0, 256, 1);
    complete(1'b0, 2'b00, 1'b0);
    issue(2'b11, 256, 256, 0);
    complete(1'b0, 2'b00, 1'b0);
    issue(2'b11, 512, 88, 3);
    complete(1'b1, 2'b00, 1'b0);
    frame_from(2'b00, 0);

    // Asynchronous reset while a request is pending.
    start_frame(2'b01);
    usedw = 10'd1023;
    @(negedge clk);
    check("pre_rst_req", 32'(o_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_req", 32'(o_req), 32'd0);
    check("async_rst_done", 32'(o_done), 32'd1);
    check("async_rst_addr", 32'(o_addr), 32'd0);
    check("async_rst_len", 32'(o_len), 32'd0);
    @(negedge clk);
    rst_n = 1'b1; usedw = '0;
    start_frame(2'b10);
    frame_from(2'b10, 0);

    // Random frames.
    repeat (4) begin
      rb = 2'($urandom);
      start_frame(rb);
      frame_from(rb, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
